// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM encoding and sizing constants for the 4-phase CDC receiver
package cdc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_e;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int XFER_CNT_WIDTH = 16;
endpackage

// File: rtl/cdc_handshake_rx_sync_bit.sv
// sync_bit: N-stage single-bit synchronizer, async active-high reset to 0
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx: 4-phase req/ack CDC receiver with valid/ready output; CDC_RX_XFER_CNT_EN adds xfer_count
module cdc_handshake_rx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ack_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  out_ready
`ifdef CDC_RX_XFER_CNT_EN
  ,
  output logic [XFER_CNT_WIDTH-1:0] xfer_count
`endif
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, ack_q, ack_d, req_s;
  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_in),
    .q  (req_s)
  );
  // data_in is only sampled once req_s proves the source has held it stable
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: if (req_s) begin
        data_d  = data_in;
        valid_d = 1'b1;
        state_d = VALID;
      end
      VALID: if (out_ready) begin
        valid_d = 1'b0;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: if (!req_s) begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign ack_out    = ack_q;
`ifdef CDC_RX_XFER_CNT_EN
  logic [XFER_CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (valid_q && out_ready) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb_cdc_handshake_rx: table-driven and hand-written sequences with a scoreboard of delivered words
module tb_cdc_handshake_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_in = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] data_in = '0;
  logic ack_out, data_valid;
  logic [31:0] data_out;
`ifdef CDC_RX_XFER_CNT_EN
  logic [15:0] xfer_count;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;
  int delivered = 0;
  logic [31:0] sb_q[$];
  typedef struct {
    logic [31:0] data;
    int          ready_delay;
  } vec_t;
  vec_t vecs[5];

  cdc_handshake_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .data_out  (data_out),
    .data_valid(data_valid),
    .out_ready (out_ready)
`ifdef CDC_RX_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid_seen"}, {31'd0, data_valid}, 32'd1);
  endtask

  task automatic wait_ack_low(input string name);
    int n = 0;
    while (ack_out && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_ack_low"}, {31'd0, ack_out}, 32'd0);
  endtask

  always @(negedge clk)
    if (!rst && data_valid && out_ready) begin
      delivered++;
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got word %h expected none", data_out);
      end else chk("sb_word", data_out, sb_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{'{32'h1F184FE4, 0}, '{32'h11111111, 3}, '{32'h1F1F1F1F, 0},
             '{32'h1234EFEF, 1}, '{32'hEEEEEEEE, 10}};
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_data", data_out, 32'd0);
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_ack", {31'd0, ack_out}, 32'd0);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    chk("idle_ready_valid", {31'd0, data_valid}, 32'd0);
    chk("idle_ready_ack", {31'd0, ack_out}, 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = vecs[i].data;
      sb_q.push_back(vecs[i].data);
      req_in = 1'b1;
      out_ready = (vecs[i].ready_delay == 0);
      wait_valid("tbl");
      for (int k = 0; k < vecs[i].ready_delay; k++) begin
        chk("bp_valid", {31'd0, data_valid}, 32'd1);
        chk("bp_data", data_out, vecs[i].data);
        chk("bp_ack", {31'd0, ack_out}, 32'd0);
        tick();
      end
      out_ready = 1'b1;
      tick();
      chk("tbl_ack", {31'd0, ack_out}, 32'd1);
      chk("tbl_valid_drop", {31'd0, data_valid}, 32'd0);
      out_ready = 1'b0;
      req_in = 1'b0;
      data_in = ~vecs[i].data;
      wait_ack_low("tbl");
      chk("tbl_hold", data_out, vecs[i].data);
    end
    chk("b2b_count", delivered, 32'd5);
    chk("b2b_sb_empty", sb_q.size(), 32'd0);
`ifdef CDC_RX_XFER_CNT_EN
    chk("b2b_xfer_count", {16'd0, xfer_count}, 32'd5);
`endif
    data_in = 32'h1234EFEF;
    sb_q.push_back(32'h1234EFEF);
    out_ready = 1'b1;
    req_in = 1'b1;
    tick();
    chk("lat_e1", {31'd0, data_valid}, 32'd0);
    tick();
    chk("lat_e2", {31'd0, data_valid}, 32'd0);
    tick();
    chk("lat_e3", {31'd0, data_valid}, 32'd1);
    chk("lat_data", data_out, 32'h1234EFEF);
    tick();
    chk("lat_one_cycle", {31'd0, data_valid}, 32'd0);
    chk("lat_ack_up", {31'd0, ack_out}, 32'd1);
    req_in = 1'b0;
    tick();
    chk("lat_ack_f1", {31'd0, ack_out}, 32'd1);
    tick();
    chk("lat_ack_f2", {31'd0, ack_out}, 32'd1);
    tick();
    chk("lat_ack_f3", {31'd0, ack_out}, 32'd0);
    out_ready = 1'b0;
    data_in = 32'hA5A55A5A;
    sb_q.push_back(32'hA5A55A5A);
    req_in = 1'b1;
    wait_valid("viol");
    req_in = 1'b0;
    repeat (4) tick();
    chk("viol_valid_hold", {31'd0, data_valid}, 32'd1);
    chk("viol_data_hold", data_out, 32'hA5A55A5A);
    chk("viol_no_ack", {31'd0, ack_out}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("viol_ack_up", {31'd0, ack_out}, 32'd1);
    out_ready = 1'b0;
    tick();
    chk("viol_ack_down", {31'd0, ack_out}, 32'd0);
    repeat (4) tick();
    chk("viol_idle", {31'd0, data_valid}, 32'd0);
    data_in = 32'hC0DEC0DE;
    sb_q.push_back(32'hC0DEC0DE);
    out_ready = 1'b1;
    req_in = 1'b1;
    wait_valid("rstm");
    tick();
    chk("rstm_in_ack", {31'd0, ack_out}, 32'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstm_ack_async", {31'd0, ack_out}, 32'd0);
    chk("rstm_data_clr", data_out, 32'd0);
    tick();
    tick();
    chk("rstm_ack_held", {31'd0, ack_out}, 32'd0);
    sb_q.push_back(32'hC0DEC0DE);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_valid("rstm_redo");
    chk("rstm_redo_data", data_out, 32'hC0DEC0DE);
    tick();
    chk("rstm_redo_ack", {31'd0, ack_out}, 32'd1);
    out_ready = 1'b0;
    req_in = 1'b0;
    wait_ack_low("rstm");
    repeat (3) tick();
    chk("final_count", delivered, 32'd9);
    chk("final_sb_empty", sb_q.size(), 32'd0);
`ifdef CDC_RX_XFER_CNT_EN
    chk("final_xfer_count", {16'd0, xfer_count}, 32'd1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
Receive end of a 4-phase req/ack clock-domain crossing. Lives entirely in the destination clock domain.
Synchronizes an asynchronous req from the source domain and captures the source-held data bus. Presents the word downstream with a valid/ready handshake, then returns ack to the source.
Pairs with a source-side transmitter that holds data stable from req rise until ack is seen.

Parameters:
DATA_WIDTH, 32, width of transferred word
SYNC_STAGES, 2, flops in req synchronizer chain (legal 2..4)

Ports:
clk  input  1  destination-domain clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
req_in  input  1  4-phase request from source domain, asynchronous to clk
data_in  input  DATA_WIDTH  source data bus; stable whenever req_in high
ack_out  output  1  4-phase acknowledge to source domain, registered
data_out  output  DATA_WIDTH  captured word, registered
data_valid  output  1  data_out valid to downstream
out_ready  input  1  downstream accepts data_out when high with data_valid

Behaviour:
- Reset (async assert, sync release):
  - sync chain = 0, state = IDLE
  - data_out = 0, data_valid = 0, ack_out = 0
- req_in passes through SYNC_STAGES flops, giving req_s. data_in is never synchronized; it is sampled only once req_s = 1.
- FSM, all outputs registered:
  - IDLE: on req_s = 1, capture data_in into data_out, set data_valid = 1, go to VALID.
  - VALID: hold data_out and data_valid. When out_ready = 1, clear data_valid, set ack_out = 1, go to ACK.
  - ACK: hold ack_out = 1. On req_s = 0, clear ack_out and go to IDLE.
- Latency:
  - req_in rise to data_valid high: SYNC_STAGES+1 clk edges.
  - Accept (valid & ready) to ack_out high: next edge.
  - req_in fall to ack_out low: SYNC_STAGES+1 edges.
- Boundary cases:
  - out_ready already high when data_valid first rises: accepted in that first valid cycle; data_valid is high exactly 1 cycle.
  - out_ready is ignored when data_valid = 0.
  - data_out holds its last captured value in IDLE/ACK. It is never cleared except by reset.
  - Back-to-back: a new capture needs IDLE. Minimum period is one full 4-phase cycle, so no overrun is possible.
- Protocol violation: req_s falls while in VALID. Stay in VALID and keep the data. ack_out is still raised on acceptance, then drops one edge later, since ACK sees req_s = 0 at once.
- Reset mid-transfer: ack_out drops immediately. If req_in is still high after release, the word is re-captured and delivered again. Duplicate delivery is accepted behaviour; the source owns de-duplication.

Optional Feature:
- Macro: CDC_RX_XFER_CNT_EN.
- Defined: adds output xfer_count [15:0].
  - Increments on each valid & ready acceptance and wraps 16'hFFFF to 0.
  - Reset value is 0.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Package cdc_pkg:
  - FSM state encoding (IDLE=2'd0, VALID=2'd1, ACK=2'd2)
  - DEFAULT_SYNC_STAGES = 2
  - XFER_CNT_WIDTH = 16
- Sub-module sync_bit: N-stage single-bit synchronizer, async active-high reset to 0, parameter STAGES. The source-side transmitter reuses it for ack.

Test Plan:
- Reset release, req_in = 0: data_out = 0, data_valid = 0, ack_out = 0 held indefinitely.
- data_in = 32'h1234EFEF, req_in raised, out_ready = 1:
  - data_valid high 1 cycle, 3 edges after req (SYNC_STAGES = 2), data_out = 32'h1234EFEF.
  - ack_out high the next edge.
  - Drop req_in: ack_out low 3 edges later.
- Backpressure, data_in = 32'hEEEEEEEE, out_ready = 0 for 10 cycles:
  - data_valid stays high with data stable, ack_out = 0.
  - Raise out_ready: ack_out high one edge later.
- Five back-to-back 4-phase transfers (1F184FE4, 11111111, 1F1F1F1F, 1234EFEF, EEEEEEEE): downstream sees exactly 5 words in order, no duplicates. With CDC_RX_XFER_CNT_EN, xfer_count = 5.
- Reset asserted in ACK with req_in high, then released: ack_out = 0 during reset; same word re-delivered once, data_valid pulse seen.
- CDC_RX_XFER_CNT_EN, preload via 65536 transfers: xfer_count wraps to 0 on the 65536th acceptance.
